// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
// Bundles the request/response signals between decode/control and the
// iterative RV32M multiply/divide unit.
//   master : issuer (drives start/op/operands/tag, observes busy/done/result)
//   slave  : muldiv_unit
// Signals:
//   start     request, sampled only while the unit is idle
//   op        funct3 (0 MUL .. 7 REMU)
//   rs1_data  operand A (multiplicand / dividend)
//   rs2_data  operand B (multiplier / divisor)
//   rd_in     destination register tag
//   busy      operation in flight (pipeline stall)
//   done      one-cycle completion pulse, register-file write enable
//   result    result for the register-file write data
//   rd_out    latched tag for the register-file write address
// -----------------------------------------------------------------------------
interface muldiv_unit_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
);
  logic                     start;
  logic [2:0]               op;
  logic [DATA_WIDTH-1:0]    rs1_data;
  logic [DATA_WIDTH-1:0]    rs2_data;
  logic [ADDRESS_WIDTH-1:0] rd_in;
  logic                     busy;
  logic                     done;
  logic [DATA_WIDTH-1:0]    result;
  logic [ADDRESS_WIDTH-1:0] rd_out;

  modport master (
    output start, op, rs1_data, rs2_data, rd_in,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, op, rs1_data, rs2_data, rd_in,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit. One shift-add (multiply) or one
// restoring-subtract (divide) step per cycle on operand magnitudes, followed by
// a sign fix-up / result-select cycle.
//   IDLE -> CALC (DATA_WIDTH cycles) -> FINISH -> DONE (done=1) -> IDLE
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   muldiv_unit_if.slave (start/op/rs1_data/rs2_data/rd_in in,
//         busy/done/result/rd_out out)
// Optional feature (macro MULDIV_FAST_SPECIAL_EN):
//   When defined, zero-operand multiplies, divide-by-zero and signed divide
//   overflow are resolved on the acceptance edge (IDLE -> DONE) with the same
//   result values as the iterative path; busy never rises for them.
//   When undefined, every op takes the full iterative path.
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, FINISH, DONE} state_t;

  state_t state_reg, state_next;

  logic [2:0]               op_reg;
  logic [ADDRESS_WIDTH-1:0] rd_reg;
  logic                     neg_reg;     // final value must be negated
  logic [DATA_WIDTH-1:0]    addend_reg;  // |rs1| for multiply, |rs2| for divide
  logic [DATA_WIDTH-1:0]    hi_reg;      // product high half / partial remainder
  logic [DATA_WIDTH-1:0]    lo_reg;      // multiplier bits / quotient bits
  logic [CW-1:0]            cnt_reg;
  logic [DATA_WIDTH-1:0]    result_reg;
  logic [ADDRESS_WIDTH-1:0] rd_out_reg;

  // ---------------------------------------------------------------------------
  // Operand decode on the incoming request (used only at the acceptance edge)
  // ---------------------------------------------------------------------------
  logic                  a_signed_in, b_signed_in, a_neg_in, b_neg_in, neg_in;
  logic [DATA_WIDTH-1:0] a_mag_in, b_mag_in;

  always_comb begin
    a_signed_in = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                  (bus.op == OP_DIV)  || (bus.op == OP_REM);
    b_signed_in = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    a_neg_in    = a_signed_in && bus.rs1_data[DATA_WIDTH-1];
    b_neg_in    = b_signed_in && bus.rs2_data[DATA_WIDTH-1];
    a_mag_in    = a_neg_in ? -bus.rs1_data : bus.rs1_data;
    b_mag_in    = b_neg_in ? -bus.rs2_data : bus.rs2_data;
    // Remainder follows the dividend sign; product and quotient follow the XOR.
    neg_in      = ((bus.op == OP_REM) || (bus.op == OP_REMU)) ? a_neg_in
                                                             : (a_neg_in ^ b_neg_in);
  end

`ifdef MULDIV_FAST_SPECIAL_EN
  // Cases whose answer is known from the operands alone.
  logic                  special_in;
  logic [DATA_WIDTH-1:0] special_value;

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    special_in    = 1'b0;
    special_value = '0;
    if (!bus.op[2]) begin
      if ((bus.rs1_data == '0) || (bus.rs2_data == '0)) begin
        special_in    = 1'b1;
        special_value = '0;
      end
    end else if (bus.rs2_data == '0) begin
      special_in    = 1'b1;
      special_value = bus.op[1] ? bus.rs1_data : '1;
    end else if (!bus.op[0] && (bus.rs1_data == MOST_NEG) && (bus.rs2_data == '1)) begin
      special_in    = 1'b1;
      special_value = bus.op[1] ? '0 : MOST_NEG;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH:0]   add_sum, r_shift, r_diff;
  logic [DATA_WIDTH-1:0] hi_step, lo_step;

  always_comb begin
    add_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, addend_reg} : '0);
    r_shift = {hi_reg, lo_reg[DATA_WIDTH-1]};
    r_diff  = r_shift - {1'b0, addend_reg};
    hi_step = add_sum[DATA_WIDTH:1];
    lo_step = {add_sum[0], lo_reg[DATA_WIDTH-1:1]};
    if (op_reg[2]) begin
      // Restoring division: keep the difference when it did not go negative.
      if (!r_diff[DATA_WIDTH]) begin
        hi_step = r_diff[DATA_WIDTH-1:0];
        lo_step = {lo_reg[DATA_WIDTH-2:0], 1'b1};
      end else begin
        hi_step = r_shift[DATA_WIDTH-1:0];
        lo_step = {lo_reg[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sign fix-up and result select
  // ---------------------------------------------------------------------------
  logic [2*DATA_WIDTH-1:0] prod_fix;
  logic [DATA_WIDTH-1:0]   quo_fix, rem_fix, final_value;

  always_comb begin
    prod_fix = neg_reg ? -{hi_reg, lo_reg} : {hi_reg, lo_reg};
    // Divide-by-zero yields all-ones quotient bits on magnitudes, but the sign
    // fix-up would disturb it for a negative dividend, so force all-ones.
    // The remainder path already returns rs1, and most-negative / -1 falls out
    // of the magnitude datapath (quotient 2^(N-1), remainder 0) unchanged.
    quo_fix  = (addend_reg == '0) ? '1 : (neg_reg ? -lo_reg : lo_reg);
    rem_fix  = neg_reg ? -hi_reg : hi_reg;
    case (op_reg)
      OP_MUL:             final_value = prod_fix[DATA_WIDTH-1:0];
      3'd1, 3'd2, 3'd3:   final_value = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
      3'd4, 3'd5:         final_value = quo_fix;
      default:            final_value = rem_fix;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = CALC;
`ifdef MULDIV_FAST_SPECIAL_EN
          if (special_in) state_next = DONE;
`endif
        end
      end
      CALC:    if (cnt_reg == CW'(DATA_WIDTH - 1)) state_next = FINISH;
      FINISH:  state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg     <= '0;
      rd_reg     <= '0;
      neg_reg    <= 1'b0;
      addend_reg <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
      rd_out_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            op_reg     <= bus.op;
            rd_reg     <= bus.rd_in;
            neg_reg    <= neg_in;
            addend_reg <= bus.op[2] ? b_mag_in : a_mag_in;
            hi_reg     <= '0;
            lo_reg     <= bus.op[2] ? a_mag_in : b_mag_in;
            cnt_reg    <= '0;
`ifdef MULDIV_FAST_SPECIAL_EN
            if (special_in) begin
              result_reg <= special_value;
              rd_out_reg <= bus.rd_in;
            end
`endif
          end
        end
        CALC: begin
          hi_reg  <= hi_step;
          lo_reg  <= lo_step;
          cnt_reg <= cnt_reg + 1'b1;
        end
        FINISH: begin
          result_reg <= final_value;
          rd_out_reg <= rd_reg;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state_reg == CALC) || (state_reg == FINISH);
  assign bus.done   = (state_reg == DONE);
  assign bus.result = result_reg;
  assign bus.rd_out = rd_out_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed vectors with hand-computed results. The stimulus process pushes the
// expected result, tag, acceptance cycle and busy length into a scoreboard
// queue; a monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
  localparam int W  = 32;
  localparam int AW = 5;
  localparam int NV = 26;

`ifdef MULDIV_FAST_SPECIAL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [AW-1:0] rd;
    logic [W-1:0]  exp;
    logic          special;
  } vec_t;

  typedef struct {
    logic [W-1:0]  result;
    logic [AW-1:0] rd;
    int            accept;
    int            lat;
    int            busy_cycles;
    string         name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_unit_if #(.DATA_WIDTH(W), .ADDRESS_WIDTH(AW)) bus();

  muldiv_unit #(.DATA_WIDTH(W), .ADDRESS_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   cycle_count = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];
  vec_t vecs [NV];
  string op_names [8] = '{"MUL", "MULH", "MULHSU", "MULHU", "DIV", "DIVU", "REM", "REMU"};

  always @(posedge clk) cycle_count <= cycle_count + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  bit prev_done = 1'b0;
  int busy_cnt  = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (prev_done) check("done_pulse_width", 32'(bus.done), 32'd0);
      if (bus.done === 1'b1) begin
        check("scoreboard_nonempty_on_done", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          $display("txn %s: result=0x%08h rd=%0d latency=%0d busy=%0d",
                   e.name, bus.result, bus.rd_out, cycle_count - e.accept, busy_cnt);
          check({e.name, " result"}, bus.result, e.result);
          check({e.name, " rd_out"}, 32'(bus.rd_out), 32'(e.rd));
          check({e.name, " latency"}, 32'(cycle_count - e.accept), 32'(e.lat));
          check({e.name, " busy_cycles"}, 32'(busy_cnt), 32'(e.busy_cycles));
        end
        busy_cnt = 0;
      end
      prev_done = (bus.done === 1'b1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a negedge with the DUT idle)
  // ---------------------------------------------------------------------------
  task automatic push_exp(input string name, input logic [W-1:0] res,
                          input logic [AW-1:0] rd, input bit fast_case);
    exp_t e;
    e.result      = res;
    e.rd          = rd;
    e.accept      = cycle_count;
    e.lat         = fast_case ? 0 : W + 1;
    e.busy_cycles = fast_case ? 0 : W + 1;
    e.name        = name;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check({name, " done_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_op(input vec_t v, input int idx);
    string name;
    name = $sformatf("%s#%0d", op_names[v.op], idx);
    bus.start    = 1'b1;
    bus.op       = v.op;
    bus.rs1_data = v.a;
    bus.rs2_data = v.b;
    bus.rd_in    = v.rd;
    @(posedge clk);
    #1;
    push_exp(name, v.exp, v.rd, FAST && v.special);
    @(negedge clk);
    // Inputs need not be held after acceptance.
    bus.start    = 1'b0;
    bus.rs1_data = $urandom;
    bus.rs2_data = $urandom;
    bus.rd_in    = AW'($urandom);
    wait_drain(name);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int  n;
    bit  seen_done;

    //            op    rs1           rs2           rd     expected      special
    vecs[0]  = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000, 1'b0};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 5'd3,  32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd4,  32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 5'd6,  32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{3'd5, 32'hFFFFFFF9, 32'h00000002, 5'd7,  32'h7FFFFFFC, 1'b0};
    vecs[7]  = '{3'd7, 32'hFFFFFFF9, 32'h00000002, 5'd8,  32'h00000001, 1'b0};
    vecs[8]  = '{3'd4, 32'h00000005, 32'h00000000, 5'd9,  32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{3'd5, 32'h00000005, 32'h00000000, 5'd10, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{3'd6, 32'h00000005, 32'h00000000, 5'd11, 32'h00000005, 1'b1};
    vecs[11] = '{3'd7, 32'h00000005, 32'h00000000, 5'd12, 32'h00000005, 1'b1};
    vecs[12] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1'b1};
    vecs[13] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h00000000, 1'b1};
    vecs[14] = '{3'd4, 32'h00000064, 32'hFFFFFFF9, 5'd15, 32'hFFFFFFF2, 1'b0};
    vecs[15] = '{3'd6, 32'h00000064, 32'hFFFFFFF9, 5'd16, 32'h00000002, 1'b0};
    vecs[16] = '{3'd6, 32'hFFFFFF9C, 32'h00000007, 5'd17, 32'hFFFFFFFE, 1'b0};
    vecs[17] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 1'b0};
    vecs[18] = '{3'd1, 32'h80000000, 32'h80000000, 5'd19, 32'h40000000, 1'b0};
    vecs[19] = '{3'd0, 32'h00001234, 32'h00000000, 5'd20, 32'h00000000, 1'b1};
    vecs[20] = '{3'd3, 32'h00000000, 32'hFFFFFFFF, 5'd21, 32'h00000000, 1'b1};
    vecs[21] = '{3'd6, 32'hFFFFFFF9, 32'h00000000, 5'd22, 32'hFFFFFFF9, 1'b1};
    vecs[22] = '{3'd4, 32'hFFFFFFF9, 32'h00000000, 5'd23, 32'hFFFFFFFF, 1'b1};
    vecs[23] = '{3'd3, 32'h80000000, 32'h00000004, 5'd24, 32'h00000002, 1'b0};
    vecs[24] = '{3'd0, 32'h00010000, 32'h00010000, 5'd25, 32'h00000000, 1'b0};
    vecs[25] = '{3'd5, 32'h00000064, 32'h00000007, 5'd26, 32'h0000000E, 1'b0};

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.op       = '0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.rd_in    = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset busy",   32'(bus.busy),   32'd0);
    check("reset done",   32'(bus.done),   32'd0);
    check("reset result", bus.result,      32'd0);
    check("reset rd_out", 32'(bus.rd_out), 32'd0);

    for (int i = 0; i < NV; i++) run_op(vecs[i], i);

    // start held high through a whole op: the second request is taken only in
    // the IDLE cycle following DONE.
    bus.start    = 1'b1;
    bus.op       = 3'd0;
    bus.rs1_data = 32'd3;
    bus.rs2_data = 32'd4;
    bus.rd_in    = 5'd1;
    @(posedge clk);
    #1 push_exp("held_start_first", 32'd12, 5'd1, 1'b0);
    @(negedge clk);
    bus.op       = 3'd5;
    bus.rs1_data = 32'd100;
    bus.rs2_data = 32'd7;
    bus.rd_in    = 5'd2;
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("held_start done_timeout", 32'(n), 32'd0);
    @(posedge clk);        // DONE -> IDLE
    @(posedge clk);        // acceptance of the second request
    #1 push_exp("held_start_second", 32'd14, 5'd2, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain("held_start_second");

    // Reset in the middle of CALC discards the op without a done pulse.
    bus.start    = 1'b1;
    bus.op       = 3'd0;
    bus.rs1_data = 32'h00001234;
    bus.rs2_data = 32'h00005678;
    bus.rd_in    = 5'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst busy",   32'(bus.busy),   32'd0);
    check("mid_rst done",   32'(bus.done),   32'd0);
    check("mid_rst result", bus.result,      32'd0);
    check("mid_rst rd_out", 32'(bus.rd_out), 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    check("mid_rst no_done_pulse", 32'(seen_done), 32'd0);

    // Unit still works after the mid-flight reset.
    run_op(vecs[0], 100);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
